// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer for an external N-decade BCD counter: turns command pulses
// into a prescaled count strobe and a clear pulse, with lap capture, alarm and overflow.
module bcd_stopwatch_ctrl #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic           clear,
  input  logic           lap,
  input  logic [4*N-1:0] target,
  input  logic [4*N-1:0] q_flat,
  output logic           cnt_en,
  output logic           cnt_clr,
  output logic [4*N-1:0] lap_q,
  output logic           lap_valid,
  output logic           running,
  output logic           alarm,
  output logic           overflow
);

  localparam int W     = 4 * N;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [W-1:0]     ALL_NINES = {N{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             match;
  logic             at_nines;
  logic             lap_take;

  // A zero target disables the alarm; non-BCD targets are compared raw and simply never hit.
  assign match    = (target != '0) && (q_flat == target);
  assign at_nines = (q_flat == ALL_NINES);
  assign tick     = (state == RUN) && (pre == PRE_LAST);
  assign cnt_en   = tick && !clear && !stop && !match && !at_nines;
  assign running  = (state == RUN);
  assign lap_take = lap && (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pre       <= '0;
      cnt_clr   <= 1'b0;
      lap_q     <= '0;
      lap_valid <= 1'b0;
      alarm     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cnt_clr   <= clear;
      lap_valid <= lap_take;
      if (lap_take) begin
        lap_q <= q_flat;
      end

      if (clear) begin
        state    <= IDLE;
        pre      <= '0;
        alarm    <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= RUN;
              pre   <= '0;
            end
          end
          RUN: begin
            // Stop keeps pre so a resume finishes the interrupted prescaler period.
            if (stop) begin
              state <= PAUSE;
            end else if (match) begin
              state <= DONE;
              alarm <= 1'b1;
            end else if (tick && at_nines) begin
              state    <= DONE;
              overflow <= 1'b1;
            end else begin
              pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
            end
          end
          PAUSE: begin
            if (!stop && start) begin
              state <= RUN;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
